multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle variant of the RV32I core.
- Sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port.
- Drives ImmSrc to the immediate extender with encoding I=0, S=1, B=2, J=3. Drives the ALU operand muxes, the IR/PC/register-file write strobes, and a memory request that stalls on memReady.
- Adds a memory-wait watchdog and a retired-instruction counter.

---
 rtl/multicycle_pkg.sv | 55 +++++
 rtl/multicycle_ctrl_if.sv | 39 +++
 rtl/multicycle_ctrl_imm_src_dec.sv | 25 ++
 rtl/multicycle_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_pkg.sv
`default_nettype none
// ============================================================================
// Module : multicycle_pkg
// Brief  : Shared types and encodings for the multi-cycle RV32I control path.
// Rev    : 1.0 - initial release
// ============================================================================
package multicycle_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        DECODE   = 4'd2,
        MEMADR   = 4'd3,
        MEMREAD  = 4'd4,
        MEMWB    = 4'd5,
        MEMWRITE = 4'd6,
        EXECR    = 4'd7,
        EXECI    = 4'd8,
        ALUWB    = 4'd9,
        JAL      = 4'd10,
        BRANCH   = 4'd11,
        TRAP     = 4'd12
    } state_t;

    localparam logic [6:0] c_op_lw     = 7'b0000011;
    localparam logic [6:0] c_op_ialu   = 7'b0010011;
    localparam logic [6:0] c_op_sw     = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;

    // Shared with the immediate extender
    localparam logic [1:0] c_imm_i = 2'd0;
    localparam logic [1:0] c_imm_s = 2'd1;
    localparam logic [1:0] c_imm_b = 2'd2;
    localparam logic [1:0] c_imm_j = 2'd3;

    localparam logic [1:0] c_res_aluout = 2'b00;
    localparam logic [1:0] c_res_data   = 2'b01;
    localparam logic [1:0] c_res_alures = 2'b10;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;

    localparam logic [1:0] c_srcb_rs2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    localparam logic [1:0] c_aluop_add   = 2'b00;
    localparam logic [1:0] c_aluop_sub   = 2'b01;
    localparam logic [1:0] c_aluop_funct = 2'b10;

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl_if
// Brief  : Controller <-> datapath signal bundle; master is the controller.
// Rev    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        Zero;
    logic        memReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic        RegWrite;
    logic [1:0]  ImmSrc;
    logic        MemReq;
    logic        Trap;
    logic        TrapCause;
    logic [31:0] InstRet;

    modport master (
        input  op, funct3, Zero, memReady,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, ImmSrc, MemReq, Trap, TrapCause, InstRet
    );

    modport slave (
        output op, funct3, Zero, memReady,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUOp, RegWrite, ImmSrc, MemReq, Trap, TrapCause, InstRet
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl_imm_src_dec.sv
`default_nettype none
// ============================================================================
// Module : imm_src_dec
// Brief  : Opcode to immediate-format decoder, shared with the single-cycle core.
// Rev    : 1.0 - initial release
// ============================================================================
module imm_src_dec
    import multicycle_pkg::*;
(
    input  wire logic [6:0] i_op,
    output logic      [1:0] o_imm_src
);

    always_comb begin
        o_imm_src = c_imm_i;
        case (i_op)
            c_op_sw:     o_imm_src = c_imm_s;
            c_op_branch: o_imm_src = c_imm_b;
            c_op_jal:    o_imm_src = c_imm_j;
            default:     o_imm_src = c_imm_i;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : multicycle_ctrl
// Brief  : Multi-cycle RV32I main control FSM with memory watchdog and InstRet.
// Rev    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    multicycle_ctrl_if.master ctrl
);

    state_t          r_state;
    state_t          w_state_next;
    logic [TO_W-1:0] r_wd;
    logic            r_trap_cause;
    logic [31:0]     r_instret;

    logic            w_wait_state;
    logic            w_timeout;
    logic            w_retire;
    logic            w_pc_update;
    logic            w_branch;
    logic            w_adr_src;
    logic            w_mem_write;
    logic            w_ir_write;
    logic            w_reg_write;
    logic            w_mem_req;
    logic            w_trap;
    logic [1:0]      w_result_src;
    logic [1:0]      w_alu_src_a;
    logic [1:0]      w_alu_src_b;
    logic [1:0]      w_alu_op;
    logic [1:0]      w_imm_src;

    imm_src_dec u_imm_src_dec (
        .i_op      (ctrl.op),
        .o_imm_src (w_imm_src)
    );

    assign w_wait_state = (r_state == FETCH) || (r_state == MEMREAD) || (r_state == MEMWRITE);
    // memReady on the limit cycle still completes the access
    assign w_timeout    = w_wait_state && !ctrl.memReady && (r_wd == TO_W'(MEM_TIMEOUT));
    assign w_retire     = (w_state_next == FETCH) &&
                          ((r_state == MEMWB) || (r_state == MEMWRITE) ||
                           (r_state == ALUWB) || (r_state == BRANCH));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   w_state_next = FETCH;
            FETCH: begin
                if (w_timeout)          w_state_next = TRAP;
                else if (ctrl.memReady) w_state_next = DECODE;
            end
            DECODE: begin
                case (ctrl.op)
                    c_op_lw, c_op_sw: w_state_next = MEMADR;
                    c_op_r:           w_state_next = EXECR;
                    c_op_ialu:        w_state_next = EXECI;
                    c_op_jal:         w_state_next = JAL;
                    c_op_branch:      w_state_next = (ctrl.funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    default:          w_state_next = TRAP;
                endcase
            end
            MEMADR: w_state_next = (ctrl.op == c_op_sw) ? MEMWRITE : MEMREAD;
            MEMREAD: begin
                if (w_timeout)          w_state_next = TRAP;
                else if (ctrl.memReady) w_state_next = MEMWB;
            end
            MEMWB:  w_state_next = FETCH;
            MEMWRITE: begin
                if (w_timeout)          w_state_next = TRAP;
                else if (ctrl.memReady) w_state_next = FETCH;
            end
            EXECR:  w_state_next = ALUWB;
            EXECI:  w_state_next = ALUWB;
            ALUWB:  w_state_next = FETCH;
            JAL:    w_state_next = ALUWB;
            BRANCH: w_state_next = FETCH;
            TRAP:   w_state_next = TRAP;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_req    = 1'b0;
        w_trap       = 1'b0;
        w_result_src = c_res_aluout;
        w_alu_src_a  = c_srca_pc;
        w_alu_src_b  = c_srcb_rs2;
        w_alu_op     = c_aluop_add;
        case (r_state)
            FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = c_srcb_four;
                w_result_src = c_res_alures;
                w_ir_write   = ctrl.memReady;
                w_pc_update  = ctrl.memReady;
            end
            DECODE: begin
                w_alu_src_a = c_srca_oldpc;
                w_alu_src_b = c_srcb_imm;
            end
            MEMADR: begin
                w_alu_src_a = c_srca_rs1;
                w_alu_src_b = c_srcb_imm;
            end
            MEMREAD: begin
                w_adr_src = 1'b1;
                w_mem_req = 1'b1;
            end
            MEMWB: begin
                w_result_src = c_res_data;
                w_reg_write  = 1'b1;
            end
            MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
            end
            EXECR: begin
                w_alu_src_a = c_srca_rs1;
                w_alu_op    = c_aluop_funct;
            end
            EXECI: begin
                w_alu_src_a = c_srca_rs1;
                w_alu_src_b = c_srcb_imm;
                w_alu_op    = c_aluop_funct;
            end
            ALUWB:  w_reg_write = 1'b1;
            JAL: begin
                w_alu_src_a = c_srca_oldpc;
                w_alu_src_b = c_srcb_four;
                w_pc_update = 1'b1;
            end
            BRANCH: begin
                w_alu_src_a = c_srca_rs1;
                w_alu_op    = c_aluop_sub;
                w_branch    = 1'b1;
            end
            TRAP:   w_trap = 1'b1;
            default: ;
        endcase
    end

    // The counter restarts whenever the FSM changes state, covering every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (w_state_next != r_state) begin
            r_wd <= '0;
        end else if (w_wait_state && !ctrl.memReady) begin
            r_wd <= r_wd + 1'b1;
        end
    end

    // Illegal instructions are only detected in DECODE; every other entry is a timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trap_cause <= 1'b0;
        end else if ((w_state_next == TRAP) && (r_state != TRAP)) begin
            r_trap_cause <= (r_state != DECODE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign ctrl.PCWrite   = w_pc_update | (w_branch & (ctrl.Zero ^ ctrl.funct3[0]));
    assign ctrl.AdrSrc    = w_adr_src;
    assign ctrl.MemWrite  = w_mem_write;
    assign ctrl.IRWrite   = w_ir_write;
    assign ctrl.ResultSrc = w_result_src;
    assign ctrl.ALUSrcA   = w_alu_src_a;
    assign ctrl.ALUSrcB   = w_alu_src_b;
    assign ctrl.ALUOp     = w_alu_op;
    assign ctrl.RegWrite  = w_reg_write;
    assign ctrl.ImmSrc    = w_imm_src;
    assign ctrl.MemReq    = w_mem_req;
    assign ctrl.Trap      = w_trap;
    assign ctrl.TrapCause = r_trap_cause;
    assign ctrl.InstRet   = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_multicycle_ctrl
// Brief  : Randomized self-checking bench for multicycle_ctrl against a phase model.
// Rev    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_ctrl;

    localparam int MEM_TIMEOUT = 4;

    localparam int PH_IDLE     = 0;
    localparam int PH_FETCH    = 1;
    localparam int PH_DECODE   = 2;
    localparam int PH_MEMADR   = 3;
    localparam int PH_MEMREAD  = 4;
    localparam int PH_MEMWB    = 5;
    localparam int PH_MEMWRITE = 6;
    localparam int PH_EXECR    = 7;
    localparam int PH_EXECI    = 8;
    localparam int PH_ALUWB    = 9;
    localparam int PH_JAL      = 10;
    localparam int PH_BRANCH   = 11;
    localparam int PH_TRAP     = 12;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_instret = '0;
    logic [6:0]  cur_op = '0;
    logic [2:0]  cur_f3 = '0;
    logic [14:0] got_word;

    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TO_W        (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.master)
    );

    assign got_word = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                       bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.RegWrite, bus.MemReq, bus.Trap};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Control word each phase should present, read straight off the state table
    function automatic logic [14:0] exp_word(input int ph, input logic mr, input logic z,
                                             input logic [2:0] f3);
        logic       pcw, adr, mw, irw, rw, mreq, trp;
        logic [1:0] res, sa, sb, aop;
        {pcw, adr, mw, irw, rw, mreq, trp} = '0;
        {res, sa, sb, aop} = '0;
        case (ph)
            PH_FETCH:    begin mreq = 1; sb = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
            PH_DECODE:   begin sa = 2'b01; sb = 2'b01; end
            PH_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
            PH_MEMREAD:  begin adr = 1; mreq = 1; end
            PH_MEMWB:    begin res = 2'b01; rw = 1; end
            PH_MEMWRITE: begin adr = 1; mreq = 1; mw = 1; end
            PH_EXECR:    begin sa = 2'b10; aop = 2'b10; end
            PH_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
            PH_ALUWB:    rw = 1;
            PH_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            PH_BRANCH:   begin sa = 2'b10; aop = 2'b01; pcw = z ^ f3[0]; end
            PH_TRAP:     trp = 1;
            default: ;
        endcase
        return {pcw, adr, mw, irw, res, sa, sb, aop, rw, mreq, trp};
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0100011: return 2'd1;
            7'b1100011: return 2'd2;
            7'b1101111: return 2'd3;
            default:    return 2'd0;
        endcase
    endfunction

    // One clock: drive at the falling edge, check shortly after
    task automatic step(input int ph, input logic mr);
        @(negedge clk);
        bus.op       = cur_op;
        bus.funct3   = cur_f3;
        bus.memReady = mr;
        bus.Zero     = 1'($urandom_range(0, 1));
        #2;
        check_eq($sformatf("word ph%0d", ph), 32'(got_word),
                 32'(exp_word(ph, mr, bus.Zero, bus.funct3)));
    endtask

    task automatic step_rnd(input int ph);
        step(ph, 1'($urandom_range(0, 1)));
    endtask

    task automatic wait_phase(input int ph);
        int stalls;
        stalls = $urandom_range(0, MEM_TIMEOUT);
        for (int i = 0; i < stalls; i++) step(ph, 1'b0);
        step(ph, 1'b1);
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1 check_eq("rst async word", 32'(got_word), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n        = 1'b1;
        bus.memReady = 1'b0;
        exp_instret  = '0;
        #2;
        check_eq("idle word", 32'(got_word), 32'd0);
        check_eq("idle instret", bus.InstRet, 32'd0);
        check_eq("idle trapcause", 32'(bus.TrapCause), 32'd0);
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3);
        int stalls;
        cur_op = op;
        cur_f3 = f3;
        stalls = $urandom_range(0, MEM_TIMEOUT);
        for (int i = 0; i <= stalls; i++) begin
            step(PH_FETCH, i == stalls);
            if (i == 0) check_eq("instret", bus.InstRet, exp_instret);
        end
        step_rnd(PH_DECODE);
        check_eq("immsrc", 32'(bus.ImmSrc), 32'(exp_imm(op)));
        case (op)
            7'b0000011: begin
                step_rnd(PH_MEMADR); wait_phase(PH_MEMREAD); step_rnd(PH_MEMWB);
                exp_instret++;
            end
            7'b0100011: begin
                step_rnd(PH_MEMADR); wait_phase(PH_MEMWRITE);
                exp_instret++;
            end
            7'b0110011: begin step_rnd(PH_EXECR); step_rnd(PH_ALUWB); exp_instret++; end
            7'b0010011: begin step_rnd(PH_EXECI); step_rnd(PH_ALUWB); exp_instret++; end
            7'b1101111: begin step_rnd(PH_JAL);   step_rnd(PH_ALUWB); exp_instret++; end
            default: begin
                if (op == 7'b1100011 && f3[2:1] == 2'b00) begin
                    step_rnd(PH_BRANCH);
                    exp_instret++;
                end else begin
                    for (int i = 0; i < 20; i++) step_rnd(PH_TRAP);
                    check_eq("illegal trapcause", 32'(bus.TrapCause), 32'd0);
                    check_eq("trap instret", bus.InstRet, exp_instret);
                end
            end
        endcase
    endtask

    logic [6:0] legal_ops [6] = '{7'b0000011, 7'b0100011, 7'b0110011,
                                  7'b0010011, 7'b1101111, 7'b1100011};

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        bus.op       = '0;
        bus.funct3   = '0;
        bus.Zero     = 1'b0;
        bus.memReady = 1'b0;

        do_reset();
        run_instr(7'b0000011, 3'b010);
        run_instr(7'b0100011, 3'b010);
        run_instr(7'b1100011, 3'b000);
        run_instr(7'b1100011, 3'b001);
        run_instr(7'b1101111, 3'b000);
        for (int n = 0; n < 80; n++) begin
            op = legal_ops[$urandom_range(0, 5)];
            f3 = (op == 7'b1100011) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
            run_instr(op, f3);
        end
        step(PH_FETCH, 1'b0);
        check_eq("final instret", bus.InstRet, exp_instret);

        do_reset();
        run_instr(7'b0000000, 3'b000);
        do_reset();
        run_instr(7'b1100011, 3'b010);

        // Fetch starved past the limit
        do_reset();
        cur_op = 7'b0000011;
        for (int i = 0; i <= MEM_TIMEOUT; i++) step(PH_FETCH, 1'b0);
        for (int i = 0; i < 3; i++) step_rnd(PH_TRAP);
        check_eq("fetch timeout cause", 32'(bus.TrapCause), 32'd1);

        // memReady on the limit cycle rescues the fetch
        do_reset();
        for (int i = 0; i < MEM_TIMEOUT; i++) step(PH_FETCH, 1'b0);
        step(PH_FETCH, 1'b1);
        step_rnd(PH_DECODE);
        step_rnd(PH_MEMADR);
        step(PH_MEMREAD, 1'b1);
        step_rnd(PH_MEMWB);
        step(PH_FETCH, 1'b0);
        check_eq("rescue instret", bus.InstRet, 32'd1);
        check_eq("rescue trapcause", 32'(bus.TrapCause), 32'd0);

        // Store starved past the limit
        do_reset();
        cur_op = 7'b0100011;
        step(PH_FETCH, 1'b1);
        step_rnd(PH_DECODE);
        step_rnd(PH_MEMADR);
        for (int i = 0; i <= MEM_TIMEOUT; i++) step(PH_MEMWRITE, 1'b0);
        step_rnd(PH_TRAP);
        check_eq("store timeout cause", 32'(bus.TrapCause), 32'd1);
        check_eq("store timeout instret", bus.InstRet, 32'd0);

        // Reset during a stalled store
        do_reset();
        step(PH_FETCH, 1'b1);
        step_rnd(PH_DECODE);
        step_rnd(PH_MEMADR);
        step(PH_MEMWRITE, 1'b0);
        step(PH_MEMWRITE, 1'b0);
        #1 rst_n = 1'b0;
        #1 check_eq("abort memwrite", 32'(bus.MemWrite), 32'd0);
        check_eq("abort word", 32'(got_word), 32'd0);
        do_reset();
        run_instr(7'b0010011, 3'b000);
        step(PH_FETCH, 1'b1);
        check_eq("post abort instret", bus.InstRet, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
